// File: rtl/alu_useq.sv
// alu_useq: micro-sequencer issuing ALU rs/ws select codes for one operation
module alu_useq #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_nops,
  input  logic       cmd_wres,
  input  logic       cmd_wflg,
  input  logic       hold,
  output logic [1:0] rs,
  output logic [1:0] ws,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, WRES, WFLG, DONE} state_t;
  localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);
  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d, nops_q, nops_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wres_q, wres_d, wflg_q, wflg_d;
  // outputs decode the registered state; hold masks bus selects, reset masks everything
  assign cmd_ready = ~rst & (state_q == IDLE);
  assign busy      = ~rst & (state_q != IDLE);
  assign done      = ~rst & (state_q == DONE);
  assign rs        = (rst | hold | state_q != LOAD) ? 2'b00 : idx_q;
  assign ws        = (rst | hold) ? 2'b00 : state_q == WRES ? 2'b01 : state_q == WFLG ? 2'b10 : 2'b00;
  // next-state: bus steps advance only without hold, EXEC counts regardless
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    nops_d  = nops_q;
    wres_d  = wres_q;
    wflg_d  = wflg_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        nops_d  = cmd_nops;
        wres_d  = cmd_wres;
        wflg_d  = cmd_wflg;
        idx_d   = 2'd1;
        state_d = cmd_nops != 2'd0 ? LOAD : EXEC;
      end
      LOAD: if (!hold) begin
        if (idx_q == nops_q) state_d = EXEC;
        else idx_d = idx_q + 2'd1;
      end
      EXEC: if (cnt_q == LAST) begin
        cnt_d   = 4'd0;
        state_d = wres_q ? WRES : wflg_q ? WFLG : DONE;
      end else cnt_d = cnt_q + 4'd1;
      WRES: if (!hold) state_d = wflg_q ? WFLG : DONE;
      WFLG: if (!hold) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous reset that drops any command in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      nops_q  <= 2'd0;
      wres_q  <= 1'b0;
      wflg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nops_q  <= nops_d;
      wres_q  <= wres_d;
      wflg_q  <= wflg_d;
    end
  end
endmodule

// File: tb/tb_alu_useq.sv
// tb_alu_useq: randomized and directed checks of alu_useq against a step-queue model
module tb_alu_useq;
  typedef int iq_t[$];
  logic clk = 0;
  logic rst = 1, cmd_valid = 0, hold = 0, cmd_wres = 0, cmd_wflg = 0;
  logic [1:0] cmd_nops = 0;
  logic rdy1, busy1, done1, rdy3, busy3, done3;
  logic [1:0] rs1, ws1, rs3, ws3;
  logic [6:0] o1, o3;
  iq_t q1, q3;
  int nchk = 0, npass = 0;
  logic [6:0] t2 [7] = '{7'b0100100, 7'b0101000, 7'b0100000, 7'b0100001, 7'b0100010, 7'b0110000, 7'b1000000};
  logic [6:0] t4 [6] = '{7'b0100100, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0100001, 7'b0110000};
  logic [6:0] t5 [3] = '{7'b0100000, 7'b0110000, 7'b1000000};

  always #5 clk = ~clk;

  alu_useq #(.EXEC_CYCLES(1)) u1 (.clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_nops(cmd_nops), .cmd_wres(cmd_wres), .cmd_wflg(cmd_wflg), .hold(hold),
    .rs(rs1), .ws(ws1), .busy(busy1), .done(done1));
  alu_useq #(.EXEC_CYCLES(3)) u3 (.clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy3),
    .cmd_nops(cmd_nops), .cmd_wres(cmd_wres), .cmd_wflg(cmd_wflg), .hold(hold),
    .rs(rs3), .ws(ws3), .busy(busy3), .done(done3));

  assign o1 = {rdy1, busy1, done1, rs1, ws1};
  assign o3 = {rdy3, busy3, done3, rs3, ws3};

  // Tokens: 1..3 load Xn, 4 exec cycle, 5 result write, 6 flags write, 7 done
  function automatic iq_t nxt(iq_t q, int ec);
    if (rst) q.delete();
    else if (q.size() == 0) begin
      if (cmd_valid) begin
        for (int i = 1; i <= int'(cmd_nops); i++) q.push_back(i);
        for (int i = 0; i < ec; i++) q.push_back(4);
        if (cmd_wres) q.push_back(5);
        if (cmd_wflg) q.push_back(6);
        q.push_back(7);
      end
    end else if (!(hold && q[0] != 4 && q[0] != 7)) void'(q.pop_front());
    return q;
  endfunction

  function automatic logic [6:0] expv(iq_t q);
    int t;
    logic [1:0] r, w;
    if (rst) return 7'b0;
    if (q.size() == 0) return 7'b1000000;
    t = q[0];
    r = (t <= 3 && !hold) ? 2'(t) : 2'b00;
    w = hold ? 2'b00 : t == 5 ? 2'b01 : t == 6 ? 2'b10 : 2'b00;
    return {1'b0, 1'b1, t == 7, r, w};
  endfunction

  task automatic cmp(input string nm, input logic [6:0] act, input logic [6:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s got=%b expected=%b at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic v, input logic h, input logic [1:0] n, input logic wr, input logic wf);
    @(negedge clk);
    rst = r; cmd_valid = v; hold = h; cmd_nops = n; cmd_wres = wr; cmd_wflg = wf;
    #1;
    cmp("model_e1", o1, expv(q1));
    cmp("model_e3", o3, expv(q3));
    cmp("excl_e1", 7'((rs1 != 0 && ws1 != 0) || ws1 == 2'b11), 7'd0);
    cmp("excl_e3", 7'((rs3 != 0 && ws3 != 0) || ws3 == 2'b11), 7'd0);
    q1 = nxt(q1, 1);
    q3 = nxt(q3, 3);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    // full operation with EXEC_CYCLES = 1
    step(0, 1, 0, 2, 1, 1);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, 0, 0, 0);
      cmp($sformatf("t2_c%0d", k + 1), o1, t2[k]);
    end
    idle(4);
    // exec length with EXEC_CYCLES = 3
    step(0, 1, 0, 1, 1, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0, 0, 0);
      cmp($sformatf("t4_c%0d", k + 1), o3, t4[k]);
    end
    idle(3);
    // degenerate command
    step(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0);
      cmp($sformatf("t5_c%0d", k + 1), o1, t5[k]);
    end
    idle(4);
    // hold stall in the second load cycle
    step(0, 1, 0, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    cmp("t3_c1", o1, 7'b0100100);
    step(0, 0, 1, 0, 0, 0);
    cmp("t3_c2", o1, 7'b0100000);
    step(0, 0, 0, 0, 0, 0);
    cmp("t3_c3", o1, 7'b0101000);
    step(0, 0, 0, 0, 0, 0);
    cmp("t3_c4", o1, 7'b0101100);
    idle(8);
    // reset asserted mid-load
    step(0, 1, 0, 3, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    cmp("t1_rst1", o1, 7'b0000000);
    step(1, 0, 0, 0, 0, 0);
    cmp("t1_rst2", o1, 7'b0000000);
    step(0, 0, 0, 0, 0, 0);
    cmp("t1_after", o1, 7'b1000000);
    idle(2);
    // back-to-back: valid held high, fields change while busy
    for (int i = 0; i < 3; i++) step(0, 1, 0, 2, 1, 0);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 1, 0, 1);
    idle(8);
    // randomized traffic
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
